// File: rtl/riscv_core_md_pkg.sv
// Shared types for the M-extension issue stage: FSM states, op encodings,
// and the replay-cache key layout.
package riscv_core_md_pkg;

   // Key operand fields are sized for the widest supported datapath.
   // Narrower operands are zero-extended into them.
   localparam int MD_MAX_XLEN = 64;

   typedef enum logic [1:0] {
      MD_IDLE   = 2'd0,
      MD_LAUNCH = 2'd1,
      MD_WAIT   = 2'd2,
      MD_RESP   = 2'd3
   } md_issue_state_e;

   localparam logic [2:0] MD_OP_MUL    = 3'b000;
   localparam logic [2:0] MD_OP_MULH   = 3'b001;
   localparam logic [2:0] MD_OP_MULHSU = 3'b010;
   localparam logic [2:0] MD_OP_MULHU  = 3'b011;
   localparam logic [2:0] MD_OP_DIV    = 3'b100;
   localparam logic [2:0] MD_OP_DIVU   = 3'b101;
   localparam logic [2:0] MD_OP_REM    = 3'b110;
   localparam logic [2:0] MD_OP_REMU   = 3'b111;

   typedef struct packed {
      logic [MD_MAX_XLEN-1:0] src_a;
      logic [MD_MAX_XLEN-1:0] src_b;
      logic [2:0]             control;
      logic                   isword;
   } md_cache_key_t;

   // The top control bit selects the divide/remainder class.
   function automatic logic md_is_div(input logic [2:0] control);
      return control[2];
   endfunction

endpackage

// File: rtl/riscv_core_md_reuse_cache.sv
// One-entry replay cache: remembers the last divide-class result so an
// identical divide can be answered without re-running the unit.
module riscv_core_md_reuse_cache
   import riscv_core_md_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter bit REUSE_EN = 1'b1
) (
   input  logic            clk,
   input  logic            srst,
   input  logic            wr_en,
   input  md_cache_key_t   wr_key,
   input  logic [XLEN-1:0] wr_result,
   input  logic            wr_overflow,
   input  logic            wr_div_by_zero,
   input  md_cache_key_t   lookup_key,
   output logic            hit,
   output logic [XLEN-1:0] hit_result,
   output logic            hit_overflow,
   output logic            hit_div_by_zero
);

   logic            valid_reg;
   md_cache_key_t   key_reg;
   logic [XLEN-1:0] result_reg;
   logic            overflow_reg;
   logic            div_by_zero_reg;

   // Store key, result and flags on every completed divide.
   always_ff @(posedge clk) begin
      if (srst) begin
         valid_reg       <= 1'b0;
         key_reg         <= '0;
         result_reg      <= '0;
         overflow_reg    <= 1'b0;
         div_by_zero_reg <= 1'b0;
      end else if (wr_en) begin
         valid_reg       <= 1'b1;
         key_reg         <= wr_key;
         result_reg      <= wr_result;
         overflow_reg    <= wr_overflow;
         div_by_zero_reg <= wr_div_by_zero;
      end
   end

   // Only an exact divide-class key match is a hit; multiplies never hit.
   always_comb begin
      hit = REUSE_EN && valid_reg && (key_reg == lookup_key) &&
            md_is_div(lookup_key.control);
   end

   assign hit_result      = result_reg;
   assign hit_overflow    = overflow_reg;
   assign hit_div_by_zero = div_by_zero_reg;

endmodule

// File: rtl/riscv_core_md_issue.sv
// Issue/interlock stage in front of the multiply/divide unit: latches one
// M-extension op, launches the unit, stalls the pipe and hands the result
// to writeback over valid/ready. Repeated divides come from a replay cache.
module riscv_core_md_issue
   import riscv_core_md_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter bit REUSE_EN = 1'b1
) (
   input  logic            i_md_issue_clk,
   input  logic            i_md_issue_rst,
   input  logic            i_md_issue_valid,
   input  logic [XLEN-1:0] i_md_issue_srcA,
   input  logic [XLEN-1:0] i_md_issue_srcB,
   input  logic [2:0]      i_md_issue_control,
   input  logic            i_md_issue_isword,
   input  logic [4:0]      i_md_issue_rd,
   input  logic            i_md_issue_flush,
   output logic            o_md_issue_stall,
   output logic [XLEN-1:0] o_md_issue_unit_srcA,
   output logic [XLEN-1:0] o_md_issue_unit_srcB,
   output logic [2:0]      o_md_issue_unit_control,
   output logic            o_md_issue_unit_isword,
   output logic            o_md_issue_unit_en,
   input  logic            i_md_issue_unit_done,
   input  logic [XLEN-1:0] i_md_issue_unit_result,
   input  logic            i_md_issue_unit_overflow,
   input  logic            i_md_issue_unit_div_by_zero,
   output logic            o_md_issue_wb_valid,
   input  logic            i_md_issue_wb_ready,
   output logic [4:0]      o_md_issue_wb_rd,
   output logic [XLEN-1:0] o_md_issue_wb_result,
   output logic            o_md_issue_wb_overflow,
   output logic            o_md_issue_wb_div_by_zero
);

   md_issue_state_e state_reg, state_next;
   logic            kill_reg, kill_next;
   logic [XLEN-1:0] src_a_reg, src_b_reg, result_reg;
   logic [2:0]      control_reg;
   logic            isword_reg;
   logic [4:0]      rd_reg;
   logic            overflow_reg, div_by_zero_reg;

   logic            accept, done_fire, cache_hit;
   logic [XLEN-1:0] cache_result;
   logic            cache_overflow, cache_div_by_zero;
   md_cache_key_t   lookup_key, wr_key;

   // A flush in IDLE blocks acceptance, so the two never coincide.
   assign accept    = (state_reg == MD_IDLE) && i_md_issue_valid && !i_md_issue_flush;
   // Completion pulses outside WAIT are stale and ignored.
   assign done_fire = (state_reg == MD_WAIT) && i_md_issue_unit_done;

   // Lookup uses the live EX operands; writes use the latched ones.
   always_comb begin
      lookup_key         = '0;
      lookup_key.src_a   = MD_MAX_XLEN'(i_md_issue_srcA);
      lookup_key.src_b   = MD_MAX_XLEN'(i_md_issue_srcB);
      lookup_key.control = i_md_issue_control;
      lookup_key.isword  = i_md_issue_isword;
      wr_key             = '0;
      wr_key.src_a       = MD_MAX_XLEN'(src_a_reg);
      wr_key.src_b       = MD_MAX_XLEN'(src_b_reg);
      wr_key.control     = control_reg;
      wr_key.isword      = isword_reg;
   end

   riscv_core_md_reuse_cache #(
      .XLEN     (XLEN),
      .REUSE_EN (REUSE_EN)
   ) u_cache (
      .clk             (i_md_issue_clk),
      .srst            (i_md_issue_rst),
      .wr_en           (done_fire && md_is_div(control_reg)),
      .wr_key          (wr_key),
      .wr_result       (i_md_issue_unit_result),
      .wr_overflow     (i_md_issue_unit_overflow),
      .wr_div_by_zero  (i_md_issue_unit_div_by_zero),
      .lookup_key      (lookup_key),
      .hit             (cache_hit),
      .hit_result      (cache_result),
      .hit_overflow    (cache_overflow),
      .hit_div_by_zero (cache_div_by_zero)
   );

   // State and kill-flag register.
   always_ff @(posedge i_md_issue_clk) begin
      if (i_md_issue_rst) begin
         state_reg <= MD_IDLE;
         kill_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         kill_reg  <= kill_next;
      end
   end

   // Next-state logic and the one-cycle launch pulse.
   always_comb begin
      state_next         = state_reg;
      kill_next          = kill_reg;
      o_md_issue_unit_en = 1'b0;
      case (state_reg)
         MD_IDLE: begin
            kill_next = 1'b0;
            if (accept) state_next = cache_hit ? MD_RESP : MD_LAUNCH;
         end
         MD_LAUNCH: begin
            o_md_issue_unit_en = 1'b1;
            state_next         = MD_WAIT;
            if (i_md_issue_flush) kill_next = 1'b1;
         end
         MD_WAIT: begin
            // The unit cannot be aborted, so a killed op still waits for done.
            if (i_md_issue_flush) kill_next = 1'b1;
            if (i_md_issue_unit_done) begin
               state_next = (kill_reg || i_md_issue_flush) ? MD_IDLE : MD_RESP;
               kill_next  = 1'b0;
            end
         end
         MD_RESP: begin
            if (i_md_issue_flush || i_md_issue_wb_ready) state_next = MD_IDLE;
         end
         default: state_next = MD_IDLE;
      endcase
   end

   // Operand latches and result capture (from the unit or the cache).
   always_ff @(posedge i_md_issue_clk) begin
      if (i_md_issue_rst) begin
         src_a_reg       <= '0;
         src_b_reg       <= '0;
         control_reg     <= '0;
         isword_reg      <= 1'b0;
         rd_reg          <= '0;
         result_reg      <= '0;
         overflow_reg    <= 1'b0;
         div_by_zero_reg <= 1'b0;
      end else if (accept) begin
         src_a_reg   <= i_md_issue_srcA;
         src_b_reg   <= i_md_issue_srcB;
         control_reg <= i_md_issue_control;
         isword_reg  <= i_md_issue_isword;
         rd_reg      <= i_md_issue_rd;
         if (cache_hit) begin
            result_reg      <= cache_result;
            overflow_reg    <= cache_overflow;
            div_by_zero_reg <= cache_div_by_zero;
         end
      end else if (done_fire) begin
         result_reg      <= i_md_issue_unit_result;
         overflow_reg    <= i_md_issue_unit_overflow;
         div_by_zero_reg <= i_md_issue_unit_div_by_zero;
      end
   end

   assign o_md_issue_stall = accept ||
                             (state_reg == MD_LAUNCH) ||
                             (state_reg == MD_WAIT) ||
                             ((state_reg == MD_RESP) && !i_md_issue_wb_ready);

   assign o_md_issue_unit_srcA      = src_a_reg;
   assign o_md_issue_unit_srcB      = src_b_reg;
   assign o_md_issue_unit_control   = control_reg;
   assign o_md_issue_unit_isword    = isword_reg;
   assign o_md_issue_wb_valid       = (state_reg == MD_RESP) && !i_md_issue_flush;
   assign o_md_issue_wb_rd          = rd_reg;
   assign o_md_issue_wb_result      = result_reg;
   assign o_md_issue_wb_overflow    = overflow_reg;
   assign o_md_issue_wb_div_by_zero = div_by_zero_reg;

endmodule

// File: tb/tb_riscv_core_md_issue.sv
// Bench for riscv_core_md_issue: behavioural mul/div unit, a transaction-level
// model of the replay cache, directed scenarios and randomized ops.
module tb_riscv_core_md_issue;

   logic        clk = 1'b0;
   logic        rst, valid, flush, isword, wb_ready;
   logic [31:0] srcA, srcB;
   logic [2:0]  control;
   logic [4:0]  rd;
   logic        unit_done, unit_ovf, unit_dbz;
   logic [31:0] unit_result;

   logic        stall, unit_en, u_isword, wb_valid, wb_ovf, wb_dbz;
   logic [31:0] u_srcA, u_srcB, wb_result;
   logic [2:0]  u_control;
   logic [4:0]  wb_rd;

   riscv_core_md_issue #(.XLEN(32), .REUSE_EN(1'b1)) dut (
      .i_md_issue_clk              (clk),
      .i_md_issue_rst              (rst),
      .i_md_issue_valid            (valid),
      .i_md_issue_srcA             (srcA),
      .i_md_issue_srcB             (srcB),
      .i_md_issue_control          (control),
      .i_md_issue_isword           (isword),
      .i_md_issue_rd               (rd),
      .i_md_issue_flush            (flush),
      .o_md_issue_stall            (stall),
      .o_md_issue_unit_srcA        (u_srcA),
      .o_md_issue_unit_srcB        (u_srcB),
      .o_md_issue_unit_control     (u_control),
      .o_md_issue_unit_isword      (u_isword),
      .o_md_issue_unit_en          (unit_en),
      .i_md_issue_unit_done        (unit_done),
      .i_md_issue_unit_result      (unit_result),
      .i_md_issue_unit_overflow    (unit_ovf),
      .i_md_issue_unit_div_by_zero (unit_dbz),
      .o_md_issue_wb_valid         (wb_valid),
      .i_md_issue_wb_ready         (wb_ready),
      .o_md_issue_wb_rd            (wb_rd),
      .o_md_issue_wb_result        (wb_result),
      .o_md_issue_wb_overflow      (wb_ovf),
      .o_md_issue_wb_div_by_zero   (wb_dbz)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int txn_id   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // RISC-V M-extension semantics; returns {overflow, div_by_zero, result}.
   function automatic logic [33:0] md_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
      logic [63:0] p;
      int          sa, sb;
      longint      la_s, lb_s, lb_u;
      logic [31:0] r;
      logic        ov, dz;
      sa = a; sb = b;
      la_s = sa; lb_s = sb; lb_u = {32'b0, b};
      ov = 1'b0; dz = 1'b0; r = '0;
      case (op)
         3'b000: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
         3'b001: begin p = la_s * lb_s; r = p[63:32]; end
         3'b010: begin p = la_s * lb_u; r = p[63:32]; end
         3'b011: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
         3'b100: begin
            if (b == 0) begin r = 32'hFFFF_FFFF; dz = 1'b1; end
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r = a; ov = 1'b1; end
            else r = 32'(sa / sb);
         end
         3'b101: begin
            if (b == 0) begin r = 32'hFFFF_FFFF; dz = 1'b1; end
            else r = a / b;
         end
         3'b110: begin
            if (b == 0) begin r = a; dz = 1'b1; end
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r = 0; ov = 1'b1; end
            else r = 32'(sa % sb);
         end
         default: begin
            if (b == 0) begin r = a; dz = 1'b1; end
            else r = a % b;
         end
      endcase
      return {ov, dz, r};
   endfunction

   // Behavioural mul/div unit with configurable latency; shares the reset.
   int          unit_lat = 4;
   int          en_count = 0;
   logic [31:0] cap_a, cap_b;
   logic [2:0]  cap_op;
   bit          cap_abort;

   always @(negedge clk) if (unit_en === 1'b1) en_count++;

   initial begin
      unit_done = 1'b0; unit_result = '0; unit_ovf = 1'b0; unit_dbz = 1'b0;
      forever begin
         @(negedge clk);
         if (unit_en === 1'b1) begin
            cap_a = u_srcA; cap_b = u_srcB; cap_op = u_control; cap_abort = 1'b0;
            for (int i = 0; i < unit_lat; i++) begin
               @(posedge clk);
               if (rst) cap_abort = 1'b1;
            end
            if (!cap_abort) begin
               #1;
               unit_done = 1'b1;
               {unit_ovf, unit_dbz, unit_result} = md_ref(cap_a, cap_b, cap_op);
               check("unit_hold_a", u_srcA, cap_a);
               check("unit_hold_b", u_srcB, cap_b);
               check("unit_hold_ctl", u_control, cap_op);
               @(posedge clk);
               #1 unit_done = 1'b0;
            end
         end
      end
   end

   // Transaction-level cache model: last completed divide, if any.
   bit          m_valid = 1'b0;
   logic [31:0] m_a, m_b;
   logic [2:0]  m_op;
   logic        m_iw;

   function automatic bit model_hit(input logic [31:0] a, input logic [31:0] b,
                                    input logic [2:0] op, input logic iw);
      return m_valid && op[2] && m_a == a && m_b == b && m_op == op && m_iw == iw;
   endfunction

   task automatic model_store(input logic [31:0] a, input logic [31:0] b,
                              input logic [2:0] op, input logic iw);
      if (op[2]) begin
         m_valid = 1'b1; m_a = a; m_b = b; m_op = op; m_iw = iw;
      end
   endtask

   // Issue one op, wait for writeback, hold ready low, then handshake.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        input logic iw, input logic [4:0] d, input int lat, input int rdy_delay);
      logic [33:0] exp;
      bit          exp_hit;
      int          en0, cyc;
      exp     = md_ref(a, b, op);
      exp_hit = model_hit(a, b, op, iw);
      unit_lat = lat;
      en0 = en_count;
      @(posedge clk); #1;
      valid = 1'b1; srcA = a; srcB = b; control = op; isword = iw; rd = d;
      #1 check("stall_accept", stall, 1);
      @(posedge clk); #1;
      valid = 1'b0; srcA = $urandom; srcB = $urandom; control = 3'($urandom); rd = 5'($urandom);
      #1 cyc = 1;
      while (wb_valid !== 1'b1 && cyc < 60) begin
         check("stall_busy", stall, 1);
         @(posedge clk); #2;
         cyc++;
      end
      check("wb_latency", cyc, exp_hit ? 1 : lat + 2);
      check("en_pulses", en_count - en0, exp_hit ? 0 : 1);
      check("wb_result", wb_result, exp[31:0]);
      check("wb_overflow", wb_ovf, exp[33]);
      check("wb_div_by_zero", wb_dbz, exp[32]);
      check("wb_rd", wb_rd, d);
      check("unit_isword", u_isword, iw);
      for (int i = 0; i < rdy_delay; i++) begin
         check("stall_hold", stall, 1);
         @(posedge clk); #2;
         check("hold_valid", wb_valid, 1);
         check("hold_result", wb_result, exp[31:0]);
         check("hold_rd", wb_rd, d);
      end
      wb_ready = 1'b1;
      #1 check("stall_handshake", stall, 0);
      check("valid_handshake", wb_valid, 1);
      @(posedge clk); #1 wb_ready = 1'b0;
      #1 check("idle_after", wb_valid, 0);
      check("stall_idle", stall, 0);
      model_store(a, b, op, iw);
      txn_id++;
      $display("txn %0d op=%0d a=%h b=%h rd=%0d result=%h hit=%0d lat=%0d",
               txn_id, op, a, b, d, wb_result, exp_hit, cyc);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_stall"}, stall, 0);
      check({tag, "_en"}, unit_en, 0);
      check({tag, "_wb_valid"}, wb_valid, 0);
      check({tag, "_wb_result"}, wb_result, 0);
      check({tag, "_wb_rd"}, wb_rd, 0);
      check({tag, "_flags"}, {wb_ovf, wb_dbz, u_isword}, 0);
      check({tag, "_unit_src"}, {u_srcA, u_srcB, 29'b0, u_control}, 0);
   endtask

   logic [31:0] pool [0:5];
   logic [31:0] ra, rb;
   logic [2:0]  rop;
   logic        riw;
   int          en_base;

   initial begin
      rst = 1'b1; valid = 1'b0; flush = 1'b0; isword = 1'b0; wb_ready = 1'b0;
      srcA = '0; srcB = '0; control = '0; rd = '0;
      repeat (2) @(posedge clk);
      #1 check_all_zero("reset");
      rst = 1'b0;

      // Directed: MUL, divide replay, remainder miss, slow writeback, div-by-zero.
      do_op(32'd7, 32'd6, 3'b000, 1'b0, 5'd5, 4, 0);
      check("mul_const", wb_result, 42);
      do_op(32'd100, 32'd7, 3'b101, 1'b0, 5'd3, 3, 0);
      do_op(32'd100, 32'd7, 3'b101, 1'b0, 5'd4, 3, 0);
      do_op(32'd100, 32'd7, 3'b111, 1'b0, 5'd6, 2, 0);
      do_op(32'd123, 32'd456, 3'b011, 1'b1, 5'd7, 2, 3);
      do_op(32'd5, 32'd0, 3'b100, 1'b0, 5'd8, 3, 0);
      do_op(32'd5, 32'd0, 3'b100, 1'b0, 5'd9, 3, 0);

      // Flush while the unit is busy: no writeback, unit still completes.
      unit_lat = 6;
      en_base = en_count;
      @(posedge clk); #1;
      valid = 1'b1; srcA = 32'd1000; srcB = 32'd9; control = 3'b101; isword = 1'b0; rd = 5'd10;
      @(posedge clk); #1 valid = 1'b0;
      @(posedge clk); #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1 check("flush_no_wb", wb_valid, 0);
         @(posedge clk); #1;
      end
      check("flush_en_once", en_count - en_base, 1);
      check("flush_stall_released", stall, 0);
      model_store(32'd1000, 32'd9, 3'b101, 1'b0);
      do_op(32'd3, 32'd3, 3'b000, 1'b0, 5'd11, 2, 0);
      check("mul_after_flush", wb_result, 9);
      do_op(32'd1000, 32'd9, 3'b101, 1'b0, 5'd12, 2, 0);

      // Reset while waiting on the unit clears everything, including the cache.
      unit_lat = 8;
      @(posedge clk); #1;
      valid = 1'b1; srcA = 32'd77; srcB = 32'd5; control = 3'b100; isword = 1'b0; rd = 5'd13;
      @(posedge clk); #1 valid = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      #1 check_all_zero("midrst");
      m_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #2 check("midrst_no_wb", wb_valid, 0);
      end
      do_op(32'd100, 32'd7, 3'b101, 1'b0, 5'd14, 3, 0);

      // Randomized ops with frequent repeats to exercise replay hits.
      pool[0] = 32'd0; pool[1] = 32'd1; pool[2] = 32'd7; pool[3] = 32'd100;
      pool[4] = 32'h8000_0000; pool[5] = 32'hFFFF_FFFF;
      ra = 32'd1; rb = 32'd1; rop = 3'b000; riw = 1'b0;
      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 9) >= 4) begin
            ra  = ($urandom_range(0, 3) == 0) ? $urandom : pool[$urandom_range(0, 5)];
            rb  = ($urandom_range(0, 3) == 0) ? $urandom : pool[$urandom_range(0, 5)];
            rop = 3'($urandom);
            riw = 1'($urandom);
         end
         do_op(ra, rb, rop, riw, 5'($urandom), $urandom_range(1, 5), $urandom_range(0, 2));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
